// File: rtl/turn_signal_ctrl.sv
// -----------------------------------------------------------------------------
// turn_signal_ctrl
//
// Reads the raw left, right and hazard switches and drives the six T-bird tail
// lamps. Each switch is synchronised with two flops and then debounced. The
// debounced requests feed a sequencing FSM that only moves on a prescaled step
// tick, so the lamp cadence is independent of when a switch is operated.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive mismatching cycles needed to accept a new
//                     switch level (minimum 2)
//   STEP_CYCLES     : clock cycles per lamp step (minimum 2)
//
// Ports
//   clk_in          : system clock
//   rst_in          : asynchronous, active-high reset
//   left_in         : raw left-turn switch (asynchronous, may bounce)
//   right_in        : raw right-turn switch (asynchronous, may bounce)
//   hazard_in       : raw hazard switch (asynchronous, may bounce)
//   lamp_left_out   : left lamps, bit0 innermost .. bit2 outermost
//   lamp_right_out  : right lamps, bit0 innermost .. bit2 outermost
//   req_out         : debounced requests {hazard, right, left}
// -----------------------------------------------------------------------------
module turn_signal_ctrl #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int STEP_CYCLES     = 4194304
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       left_in,
  input  logic       right_in,
  input  logic       hazard_in,
  output logic [2:0] lamp_left_out,
  output logic [2:0] lamp_right_out,
  output logic [2:0] req_out
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PS_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0] DB_ZERO = DB_W'(0);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_CYCLES - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);
  localparam logic [PS_W-1:0] PS_ZERO = PS_W'(0);

  // Bit positions inside the request vectors.
  localparam int REQ_LEFT   = 0;
  localparam int REQ_RIGHT  = 1;
  localparam int REQ_HAZARD = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_L1     = 3'd1,
    ST_L2     = 3'd2,
    ST_L3     = 3'd3,
    ST_R1     = 3'd4,
    ST_R2     = 3'd5,
    ST_R3     = 3'd6,
    ST_HAZ_ON = 3'd7
  } state_e;

  // Lamp bar for a given step number: 0 = dark, 1..3 = lamps lit from inside.
  function automatic logic [2:0] lamp_bar(input logic [1:0] step);
    logic [2:0] bar;
    case (step)
      2'd0:    bar = 3'b000;
      2'd1:    bar = 3'b001;
      2'd2:    bar = 3'b011;
      2'd3:    bar = 3'b111;
      default: bar = 3'b000;
    endcase
    return bar;
  endfunction

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic [2:0] raw_s;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;

  assign raw_s = {hazard_in, right_in, left_in};

  // Two-flop synchroniser for all three raw switch inputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncers
  // ---------------------------------------------------------------------------
  // The counter only runs while the synchronised level differs from the
  // accepted level; any cycle of agreement throws the partial count away, so
  // a bouncing contact never accumulates towards a flip.
  logic [DB_W-1:0] db_cnt_q [3];
  logic [DB_W-1:0] db_cnt_d [3];
  logic [2:0]      deb_q;
  logic [2:0]      deb_d;

  // Next-state for the three debounce counters and accepted levels.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '{default: DB_ZERO};
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        db_cnt_d[i] = DB_ZERO;
        deb_d[i]    = deb_q[i];
      end else if (db_cnt_q[i] == DB_LAST) begin
        // Last mismatching cycle of the run: accept the new level now.
        db_cnt_d[i] = DB_ZERO;
        deb_d[i]    = ~deb_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
        deb_d[i]    = deb_q[i];
      end
    end
  end

  // Debounce counter and accepted-level registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      deb_q <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= DB_ZERO;
      end
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign req_out = deb_q;

  // ---------------------------------------------------------------------------
  // Step prescaler
  // ---------------------------------------------------------------------------
  // Free-running on purpose: requests never realign it, so the lamp rhythm
  // stays steady regardless of switch activity.
  logic [PS_W-1:0] ps_cnt_q;
  logic [PS_W-1:0] ps_cnt_d;
  logic            tick_s;

  // Prescaler wrap and step-tick decode.
  always_comb begin
    tick_s = (ps_cnt_q == PS_LAST);
    if (tick_s) begin
      ps_cnt_d = PS_ZERO;
    end else begin
      ps_cnt_d = ps_cnt_q + PS_ONE;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ps_cnt_q <= PS_ZERO;
    end else begin
      ps_cnt_q <= ps_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  // Left and right together behave exactly like hazard, so no side is ever
  // given priority over the other.
  logic haz_req_s;
  logic left_only_s;
  logic right_only_s;

  assign haz_req_s    = deb_q[REQ_HAZARD] | (deb_q[REQ_LEFT] & deb_q[REQ_RIGHT]);
  assign left_only_s  = deb_q[REQ_LEFT]  & ~deb_q[REQ_RIGHT];
  assign right_only_s = deb_q[REQ_RIGHT] & ~deb_q[REQ_LEFT];

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  state_e     state_q;
  state_e     state_d;
  logic [2:0] lamp_left_q;
  logic [2:0] lamp_left_d;
  logic [2:0] lamp_right_q;
  logic [2:0] lamp_right_d;

  // State register plus the lamp registers that track it edge for edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      lamp_left_q  <= 3'b000;
      lamp_right_q <= 3'b000;
    end else begin
      state_q      <= state_d;
      lamp_left_q  <= lamp_left_d;
      lamp_right_q <= lamp_right_d;
    end
  end

  // Next-state logic; nothing moves except on a step tick.
  always_comb begin
    state_d = state_q;
    if (tick_s) begin
      case (state_q)
        ST_IDLE: begin
          if (haz_req_s) begin
            state_d = ST_HAZ_ON;
          end else if (left_only_s) begin
            state_d = ST_L1;
          end else if (right_only_s) begin
            state_d = ST_R1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        // A started sequence runs to completion whatever the request level;
        // only hazard may cut it short.
        ST_L1:     state_d = haz_req_s ? ST_HAZ_ON : ST_L2;
        ST_L2:     state_d = haz_req_s ? ST_HAZ_ON : ST_L3;
        ST_L3:     state_d = haz_req_s ? ST_HAZ_ON : ST_IDLE;
        ST_R1:     state_d = haz_req_s ? ST_HAZ_ON : ST_R2;
        ST_R2:     state_d = haz_req_s ? ST_HAZ_ON : ST_R3;
        ST_R3:     state_d = haz_req_s ? ST_HAZ_ON : ST_IDLE;
        // Always drop to IDLE so a held hazard blinks 1:1.
        ST_HAZ_ON: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Lamp decode from the next state so the lamps change on the state's edge.
  always_comb begin
    lamp_left_d  = 3'b000;
    lamp_right_d = 3'b000;
    case (state_d)
      ST_IDLE: begin
        lamp_left_d  = 3'b000;
        lamp_right_d = 3'b000;
      end
      ST_L1: begin
        lamp_left_d  = lamp_bar(2'd1);
        lamp_right_d = 3'b000;
      end
      ST_L2: begin
        lamp_left_d  = lamp_bar(2'd2);
        lamp_right_d = 3'b000;
      end
      ST_L3: begin
        lamp_left_d  = lamp_bar(2'd3);
        lamp_right_d = 3'b000;
      end
      ST_R1: begin
        lamp_left_d  = 3'b000;
        lamp_right_d = lamp_bar(2'd1);
      end
      ST_R2: begin
        lamp_left_d  = 3'b000;
        lamp_right_d = lamp_bar(2'd2);
      end
      ST_R3: begin
        lamp_left_d  = 3'b000;
        lamp_right_d = lamp_bar(2'd3);
      end
      ST_HAZ_ON: begin
        lamp_left_d  = 3'b111;
        lamp_right_d = 3'b111;
      end
      default: begin
        lamp_left_d  = 3'b000;
        lamp_right_d = 3'b000;
      end
    endcase
  end

  assign lamp_left_out  = lamp_left_q;
  assign lamp_right_out = lamp_right_q;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// -----------------------------------------------------------------------------
// tb_turn_signal_ctrl
//
// Directed bench for turn_signal_ctrl with DEBOUNCE_CYCLES=4, STEP_CYCLES=8.
// Inputs change and outputs are sampled on the falling clock edge. The
// variable cyc counts rising edges since the last reset release, so step
// ticks update the lamps on cyc = 8, 16, 24, ... and a switch changed at
// cyc = n is reflected on req_out from cyc = n+6.
// Lamp values are compared as {2'b00, lamp_left_out, lamp_right_out}.
// -----------------------------------------------------------------------------
module tb_turn_signal_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       left_in;
  logic       right_in;
  logic       hazard_in;
  logic [2:0] lamp_left_out;
  logic [2:0] lamp_right_out;
  logic [2:0] req_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  turn_signal_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .STEP_CYCLES    (8)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .left_in       (left_in),
    .right_in      (right_in),
    .hazard_in     (hazard_in),
    .lamp_left_out (lamp_left_out),
    .lamp_right_out(lamp_right_out),
    .req_out       (req_out)
  );

  // 10 ns system clock.
  always #5 clk_in = ~clk_in;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %02h, expected %02h", tag, cyc, obs, exp);
    end
  endtask

  // Advance to the falling edge following rising edge number 'target'.
  task automatic adv(input int target);
    while (cyc < target) begin
      @(negedge clk_in);
      cyc++;
    end
  endtask

  // Advance and compare both lamp banks.
  task automatic lamps_at(input int target, input logic [7:0] exp, input string tag);
    adv(target);
    check_eq(tag, {2'b00, lamp_left_out, lamp_right_out}, exp);
  endtask

  // Advance and compare the debounced request vector.
  task automatic req_at(input int target, input logic [2:0] exp, input string tag);
    adv(target);
    check_eq(tag, {5'b00000, req_out}, {5'b00000, exp});
  endtask

  initial begin
    rst_in    = 1'b1;
    left_in   = 1'b0;
    right_in  = 1'b0;
    hazard_in = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk_in);
    check_eq("rst_lamps", {2'b00, lamp_left_out, lamp_right_out}, 8'h00);
    check_eq("rst_req", {5'b00000, req_out}, 8'h00);

    // Left sequence with left held from the moment reset is released.
    rst_in  = 1'b0;
    left_in = 1'b1;
    cyc     = 0;
    req_at(5, 3'b000, "left_deb_early");
    req_at(6, 3'b001, "left_deb_rise");
    lamps_at(7,  8'h00, "first_tick_pre");
    lamps_at(8,  8'h08, "left_L1");
    lamps_at(16, 8'h18, "left_L2");
    lamps_at(24, 8'h38, "left_L3");
    lamps_at(32, 8'h00, "left_dark");
    lamps_at(40, 8'h08, "left_L1_again");
    lamps_at(48, 8'h18, "left_L2_again");

    // Asynchronous reset in L2: outputs clear without any clock edge.
    adv(50);
    rst_in  = 1'b1;
    left_in = 1'b0;
    #1;
    check_eq("async_rst_lamps", {2'b00, lamp_left_out, lamp_right_out}, 8'h00);
    check_eq("async_rst_req", {5'b00000, req_out}, 8'h00);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    cyc    = 0;

    // Debounce: left toggles every 2 cycles for 20 cycles, then holds high.
    for (int k = 0; k <= 26; k++) begin
      adv(k);
      if (k >= 1) begin
        check_eq("deb_toggle", {5'b00000, req_out}, (k == 26) ? 8'h01 : 8'h00);
      end
      if ((k <= 20) && ((k % 2) == 0)) begin
        left_in = ((k / 2) % 2) == 0;
      end
    end
    // Request arrived after the tick at 24, so the first lamp waits for 32.
    lamps_at(24, 8'h00, "post_rst_idle");
    lamps_at(31, 8'h00, "wait_tick");
    lamps_at(32, 8'h08, "deb_left_L1");
    left_in = 1'b0;
    lamps_at(40, 8'h18, "deb_left_L2");
    lamps_at(48, 8'h38, "deb_left_L3");
    lamps_at(56, 8'h00, "deb_left_idle");

    // Early release of right after R1 has been entered.
    right_in = 1'b1;
    req_at(61, 3'b000, "right_deb_early");
    req_at(62, 3'b010, "right_deb_rise");
    lamps_at(64, 8'h01, "right_R1");
    right_in = 1'b0;
    lamps_at(72, 8'h03, "right_R2");
    lamps_at(80, 8'h07, "right_R3");
    lamps_at(88, 8'h00, "right_idle");
    req_at(88, 3'b000, "right_req_low");
    lamps_at(96, 8'h00, "right_idle_hold");

    // Hazard preemption while in L2.
    left_in = 1'b1;
    lamps_at(104, 8'h08, "haz_pre_L1");
    lamps_at(112, 8'h18, "haz_pre_L2");
    left_in   = 1'b0;
    hazard_in = 1'b1;
    req_at(118, 3'b100, "haz_req");
    lamps_at(119, 8'h18, "haz_still_L2");
    lamps_at(120, 8'h3F, "haz_on_1");
    lamps_at(128, 8'h00, "haz_off_1");
    lamps_at(136, 8'h3F, "haz_on_2");
    lamps_at(144, 8'h00, "haz_off_2");
    hazard_in = 1'b0;
    lamps_at(152, 8'h00, "haz_released");

    // Left and right together act as hazard.
    left_in  = 1'b1;
    right_in = 1'b1;
    req_at(158, 3'b011, "both_req");
    lamps_at(160, 8'h3F, "both_on_1");
    lamps_at(168, 8'h00, "both_off_1");
    lamps_at(176, 8'h3F, "both_on_2");
    lamps_at(184, 8'h00, "both_off_2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/turn_signal_ctrl.md
# turn_signal_ctrl

Input-side counterpart to the free-running LED pattern generators on the iCEstick: reads raw left, right and hazard switch inputs and drives the six T-bird tail lamps. Each raw input is synchronised and debounced, then fed to a sequencing FSM paced by a prescaled step tick. It sits between the board's switch pins and the LED pins, in the same top-level as the LED drivers.

## Interface
- DEBOUNCE_CYCLES, 120000: consecutive stable cycles required to accept a new input level (10 ms at 12 MHz); minimum 2.
- STEP_CYCLES, 4194304: clock cycles per lamp step; minimum 2.
- clk_in  input  1  system clock (12 MHz on iCEstick).
- rst_in  input  1  asynchronous, active-high reset.
- left_in  input  1  raw left-turn switch, asynchronous, active-high, may bounce.
- right_in  input  1  raw right-turn switch, same properties.
- hazard_in  input  1  raw hazard switch, same properties.
- lamp_left_out  output  3  left lamps; bit0 innermost, bit2 outermost.
- lamp_right_out  output  3  right lamps; bit0 innermost, bit2 outermost.
- req_out  output  3  debounced {hazard, right, left}; for status and test.

## Operation
- Synchroniser: two flops per raw input; reset to 0.
- Debouncer, per input: counter (width ceil(log2(DEBOUNCE_CYCLES+1))) clears whenever the synchronised value equals the debounced value. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, the debounced value flips on that edge and the counter clears. Any mismatch gap restarts the count from 0.
- Prescaler: free-running counter 0..STEP_CYCLES-1 that wraps to 0. The step tick is high for the one cycle the count equals STEP_CYCLES-1. The prescaler never restarts on requests.
- FSM states: IDLE, L1, L2, L3, R1, R2, R3, HAZ_ON. State changes occur only on tick cycles.
- From IDLE on a tick:
  - hazard, or left and right both set -> HAZ_ON.
  - left only -> L1.
  - right only -> R1.
  - no request -> stay in IDLE.
- Left sequence L1 -> L2 -> L3 -> IDLE, one step per tick, regardless of request level. Once started, a sequence always completes unless hazard preempts it. If left is still held in IDLE, the next tick restarts at L1, giving a dark step between sequences.
- Right sequence R1 -> R2 -> R3 -> IDLE, same rules.
- Hazard preemption: on a tick, debounced hazard (or left and right both set) forces HAZ_ON from any L/R state.
- From HAZ_ON on a tick, the FSM always goes to IDLE. It re-enters HAZ_ON on the following tick if the request persists, so all lamps blink 1:1.
- Lamp decode, registered and updated on the same edge as the state:
  - IDLE: both sides 000.
  - L1/L2/L3: lamp_left_out = 001/011/111; right side 000.
  - R1/R2/R3: lamp_right_out = 001/011/111; left side 000.
  - HAZ_ON: both sides 111.
- Left and right sides are never lit simultaneously except in HAZ_ON.

## Timing
- Reset values: lamp_left_out=000, lamp_right_out=000, req_out=000, FSM=IDLE, prescaler=0, debounce counters=0, synchronisers=0.
- Reset is asynchronous: all outputs go to their reset values immediately. Release mid-sequence is not special-cased: the block restarts from IDLE with prescaler 0.
- First tick after reset release occurs STEP_CYCLES cycles later.
- Raw input to req_out: 2 synchroniser cycles + DEBOUNCE_CYCLES cycles of stability.
- Debounced request to first lamp: 1 to STEP_CYCLES cycles, because the FSM waits for the next tick.
- A request that is debounced high and then low entirely between two ticks is never seen by the FSM.
- Simultaneous debounced left and right is treated as hazard; there is no left/right priority.

## Test plan
Benches use DEBOUNCE_CYCLES=4, STEP_CYCLES=8.
- Reset: assert rst_in mid-sequence in L2 -> lamps read 000 within the same cycle, without a clock edge; after release the first tick occurs at cycle 8 and req_out=000.
- Debounce: left_in toggles every 2 cycles for 20 cycles, then holds high -> req_out[0] stays 0 throughout the toggling and rises exactly 2+4 cycles after the final rising edge.
- Left sequence: hold left_in high -> lamp_left_out steps 001, 011, 111, 000, 001… on consecutive ticks; lamp_right_out stays 000.
- Early release: release right_in after R1 is entered -> sequence still shows R2=011 and R3=111, then IDLE with lamps 000 that hold.
- Hazard preempt: in L2, debounce hazard_in high -> at the next tick both sides read 111, then 000, alternating every tick while hazard is held.
- Both sides: assert left_in and right_in together from IDLE -> behaviour is identical to hazard (111/000 on both sides); req_out reads 011.
